// File: rtl/clock_modes_pkg.sv
// Clock mode definitions and the DRP register image derived from them,
// shared by the static MMCM setup and the runtime reconfiguration controller.
package clock_modes_pkg;

  typedef struct packed {
    logic [5:0] clkout0_div;
    logic [5:0] clkout1_div;
    logic [5:0] divclk_div;
    logic [5:0] clkfb_mult;
  } clock_config_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_RELEASE,
    ST_WAIT_LOCK
  } reconfig_state_e;

  localparam clock_config_t MODE0_CFG = '{clkout0_div: 6'd4, clkout1_div: 6'd8,
                                          divclk_div: 6'd1, clkfb_mult: 6'd10};
  localparam clock_config_t MODE1_CFG = '{clkout0_div: 6'd2, clkout1_div: 6'd4,
                                          divclk_div: 6'd1, clkfb_mult: 6'd10};
  localparam logic [15:0] LOCK_CNT_CFG = 16'h03E8;

  // Counter register 1: high time in [11:6], low time in [5:0].
  function automatic logic [15:0] div_reg1(input logic [5:0] d);
    logic [5:0] hi;
    logic [5:0] lo;
    hi = {1'b0, d[5:1]};
    lo = d - hi;
    return {4'b0000, hi, lo};
  endfunction

  // Counter register 2: edge (odd divide) in [7], no-count (bypass) in [6].
  function automatic logic [15:0] div_reg2(input logic [5:0] d);
    return {8'h00, d[0], d == 6'd1, 6'b000000};
  endfunction

  function automatic logic [15:0] divclk_reg(input logic [5:0] d);
    logic [15:0] r;
    r = div_reg1(d);
    return {2'b00, (d > 6'd1) && d[0], d == 6'd1, r[11:0]};
  endfunction

  function automatic drp_entry_t cfg_entry(input clock_config_t cfg, input logic [2:0] idx);
    drp_entry_t e;
    case (idx)
      3'd0:    e = '{addr: 7'h08, mask: 16'h1000, data: div_reg1(cfg.clkout0_div)};
      3'd1:    e = '{addr: 7'h09, mask: 16'hFC00, data: div_reg2(cfg.clkout0_div)};
      3'd2:    e = '{addr: 7'h0A, mask: 16'h1000, data: div_reg1(cfg.clkout1_div)};
      3'd3:    e = '{addr: 7'h0B, mask: 16'hFC00, data: div_reg2(cfg.clkout1_div)};
      3'd4:    e = '{addr: 7'h16, mask: 16'hC000, data: divclk_reg(cfg.divclk_div)};
      3'd5:    e = '{addr: 7'h14, mask: 16'h1000, data: div_reg1(cfg.clkfb_mult)};
      3'd6:    e = '{addr: 7'h15, mask: 16'hFC00, data: div_reg2(cfg.clkfb_mult)};
      default: e = '{addr: 7'h18, mask: 16'hFC00, data: LOCK_CNT_CFG};
    endcase
    return e;
  endfunction

  function automatic drp_entry_t mode_entry(input int unsigned mode, input logic [2:0] idx);
    return cfg_entry((mode == 1) ? MODE1_CFG : MODE0_CFG, idx);
  endfunction

endpackage

// File: rtl/mmcm_drp_rom.sv
// Combinational lookup of the DRP read-modify-write entry for a (mode, index) pair.
module mmcm_drp_rom
  import clock_modes_pkg::*;
#(
  parameter int MODE_W = 1,
  parameter int IDX_W  = 3
) (
  input  logic [MODE_W-1:0] mode_i,
  input  logic [IDX_W-1:0]  idx_i,
  output drp_entry_t        entry_o
);

  always_comb begin
    entry_o = mode_entry(32'(mode_i), 3'(idx_i));
  end

endmodule

// File: rtl/mmcm_reconfig_ctrl.sv
// Runtime MMCM reconfiguration: holds the MMCM in reset, rewrites its DRP
// registers by read-modify-write, releases reset and waits for lock.
module mmcm_reconfig_ctrl
  import clock_modes_pkg::*;
#(
  parameter int NUM_MODES    = 2,
  parameter int NUM_ENTRIES  = 8,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                         clk_in,
  input  logic                         rstn_in,
  input  logic                         mode_valid,
  output logic                         mode_ready,
  input  logic [$clog2(NUM_MODES)-1:0] mode_sel,
  output logic [6:0]                   drp_daddr,
  output logic                         drp_den,
  output logic                         drp_dwe,
  output logic [15:0]                  drp_di,
  input  logic [15:0]                  drp_do,
  input  logic                         drp_drdy,
  output logic                         mmcm_rst,
  input  logic                         mmcm_locked,
  output logic                         clk_ready,
  output logic                         lock_err
);

  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int CNT_W  = $clog2(LOCK_TIMEOUT + 1);

  reconfig_state_e   state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, rom_idx;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        daddr_q, daddr_d;
  logic [15:0]       di_q, di_d;
  logic              den_q, den_d, dwe_q, dwe_d, mrst_q, mrst_d;
  logic              ready_q, ready_d, clk_ready_q, clk_ready_d, err_q, err_d;
  logic              lock_meta_q, lock_sync_q;
  drp_entry_t        entry;

  // Strobes are registered, so the entry looked up is the one the next state uses.
  always_comb begin
    rom_idx = idx_q;
    if (state_q == ST_WR_WAIT) rom_idx = idx_q + 1'b1;
  end

  mmcm_drp_rom #(.MODE_W(MODE_W), .IDX_W(IDX_W)) u_rom (
    .mode_i (mode_q),
    .idx_i  (rom_idx),
    .entry_o(entry)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    daddr_d     = daddr_q;
    di_d        = di_q;
    den_d       = 1'b0;
    dwe_d       = 1'b0;
    mrst_d      = mrst_q;
    ready_d     = ready_q;
    clk_ready_d = clk_ready_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!lock_sync_q) clk_ready_d = 1'b0;
        if (mode_valid && ready_q) begin
          mode_d      = (int'(mode_sel) < NUM_MODES) ? mode_sel : '0;
          idx_d       = '0;
          err_d       = 1'b0;
          clk_ready_d = 1'b0;
          ready_d     = 1'b0;
          mrst_d      = 1'b1;
          state_d     = ST_RST;
        end
      end
      ST_RST: begin
        den_d   = 1'b1;
        daddr_d = entry.addr;
        state_d = ST_RD;
      end
      ST_RD: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (drp_drdy) begin
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          di_d    = (drp_do & entry.mask) | entry.data;
          state_d = ST_WR;
        end
      end
      ST_WR: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (drp_drdy) begin
          if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
            mrst_d  = 1'b0;
            state_d = ST_RELEASE;
          end else begin
            idx_d   = idx_q + 1'b1;
            den_d   = 1'b1;
            daddr_d = entry.addr;
            state_d = ST_RD;
          end
        end
      end
      ST_RELEASE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_sync_q) begin
          clk_ready_d = 1'b1;
          ready_d     = 1'b1;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          err_d       = 1'b1;
          clk_ready_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  // Reset lands in WAIT_LOCK so the power-up (or partial) configuration is judged by lock alone.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q     <= ST_WAIT_LOCK;
      idx_q       <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      daddr_q     <= '0;
      di_q        <= '0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      mrst_q      <= 1'b0;
      ready_q     <= 1'b0;
      clk_ready_q <= 1'b0;
      err_q       <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      mrst_q      <= mrst_d;
      ready_q     <= ready_d;
      clk_ready_q <= clk_ready_d;
      err_q       <= err_d;
      lock_meta_q <= mmcm_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign mode_ready = ready_q;
  assign drp_daddr  = daddr_q;
  assign drp_den    = den_q;
  assign drp_dwe    = dwe_q;
  assign drp_di     = di_q;
  assign mmcm_rst   = mrst_q;
  assign clk_ready  = clk_ready_q;
  assign lock_err   = err_q;

endmodule

// File: doc/mmcm_reconfig_ctrl.md
# mmcm_reconfig_ctrl

Runtime reconfiguration controller for the design's MMCM clock generator. On request it switches the generated clock to a different `clock_modes_pkg` mode. It holds the MMCM in reset, rewrites its configuration registers through the Dynamic Reconfiguration Port (DRP) by read-modify-write, releases reset, and waits for lock. It runs in the input-clock domain, beside the MMCM wrapper, and reports when the output clock is usable.

## Interface
Parameters:
- `NUM_MODES`, 2: number of selectable clock modes.
- `NUM_ENTRIES`, 8: DRP register writes per mode.
- `LOCK_TIMEOUT`, 65535: cycles to wait for `mmcm_locked` before flagging an error.

Ports:
- `clk_in` in 1: input reference clock; the only clock in the block.
- `rstn_in` in 1: reset, asynchronous, active-low.
- `mode_valid` in 1: reconfiguration request.
- `mode_ready` out 1: controller idle; a request is accepted when `mode_valid && mode_ready`.
- `mode_sel` in `$clog2(NUM_MODES)`: target mode, sampled on acceptance.
- `drp_daddr` out 7: DRP address.
- `drp_den` out 1: DRP enable, one-cycle pulse.
- `drp_dwe` out 1: DRP write enable; only asserted together with `drp_den`.
- `drp_di` out 16: DRP write data.
- `drp_do` in 16: DRP read data, valid while `drp_drdy` is high.
- `drp_drdy` in 1: DRP access complete.
- `mmcm_rst` out 1: MMCM reset, active-high.
- `mmcm_locked` in 1: MMCM lock, asynchronous to `clk_in`.
- `clk_ready` out 1: output clock is locked and stable.
- `lock_err` out 1: sticky; set on lock timeout, cleared when the next request is accepted.

## Operation
- `mmcm_locked` passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE, WAIT_LOCK.
- **RESET.** The FSM enters WAIT_LOCK so the power-up configuration locks normally. Reset values: `mmcm_rst=0`, `drp_den=0`, `drp_dwe=0`, `drp_daddr=0`, `drp_di=0`, `mode_ready=0`, `clk_ready=0`, `lock_err=0`, entry index 0.
- **IDLE.**
  - `mode_ready=1`.
  - On acceptance: latch `mode_sel`, clear `lock_err`, clear `clk_ready`, go to RST.
- **RST.** Assert `mmcm_rst`. It stays high through RELEASE. Go to RD.
- **RD.**
  - Pulse `drp_den` for one cycle with `drp_daddr = rom[mode][idx].addr`.
  - Go to RD_WAIT.
- **RD_WAIT.**
  - Wait for `drp_drdy`.
  - On `drp_drdy`, latch `drp_do` into `rd_data`, then go to WR.
- **WR.**
  - Pulse `drp_den` and `drp_dwe` together for one cycle.
  - Write data: `drp_di = (rd_data & mask) | data`. `mask` has 1 for each bit to keep. `data` bits under the mask must be 0; the ROM guarantees this.
  - Go to WR_WAIT.
- **WR_WAIT.**
  - Wait for `drp_drdy`.
  - If `idx == NUM_ENTRIES-1`, go to RELEASE. Otherwise increment `idx` and go to RD.
- **RELEASE.** Deassert `mmcm_rst`, clear the lock counter, go to WAIT_LOCK.
- **WAIT_LOCK.**
  - Synchronized lock high: set `clk_ready`, go to IDLE.
  - Counter reaching `LOCK_TIMEOUT`: set `lock_err`, go to IDLE with `clk_ready=0`. Software may retry.
- **Boundary conditions.**
  - `drp_drdy` outside RD_WAIT and WR_WAIT is ignored.
  - `mode_sel >= NUM_MODES` is accepted and treated as mode 0.
  - A `mode_valid` held high after acceptance starts no second sequence until IDLE returns.
  - A lock loss in IDLE clears `clk_ready`; the FSM does not leave IDLE.
- **Reset mid-operation.** DRP strobes and `mmcm_rst` drop asynchronously. The MMCM may hold a partial configuration. The FSM restarts in WAIT_LOCK, so `clk_ready` reflects whatever lock results.

## Timing
- Outputs are registered.
- Acceptance at cycle 0 gives `mmcm_rst=1` at cycle 1 and the first `drp_den` at cycle 2.
- With a DRP latency of L cycles (`drdy` L cycles after `den`), one entry takes 2·(L+1) cycles.
- `mmcm_rst` deasserts 1 cycle after the last `drdy`.
- `clk_ready` rises 3 cycles after `mmcm_locked` rises: 2 synchronizer cycles plus 1 register.
- `mode_ready` returns together with `clk_ready` or `lock_err`.
- `drp_den` is never high on two consecutive cycles.

## Structure
- `drp_entry_t` (`addr[6:0]`, `mask[15:0]`, `data[15:0]`) belongs in `clock_modes_pkg`, along with the per-mode entry constants. These are derived from the same `clock_config_t` values that configure the MMCM statically.
- Sub-module `mmcm_drp_rom`: combinational lookup from (mode, idx) to `drp_entry_t`. The FSM, counters and synchronizer stay in `mmcm_reconfig_ctrl`.

## Test plan
- **Power-up:** release `rstn_in`, raise `mmcm_locked` at cycle 20 → `clk_ready=1` at cycle 23, `mode_ready=1`, no `drp_den` pulses.
- **Mode switch:** DRP model with L=3 and preloaded `drp_do=16'hFFFF`; request mode 1 with entry0 {addr 7'h08, mask 16'h1000, data 16'h0041} → write of 16'h1041 to 8'h08.
  - Exactly 8 reads and 8 writes, in order.
  - `mmcm_rst` high for the whole window.
  - `clk_ready` low until lock returns.
- **Lock timeout:** `LOCK_TIMEOUT=100`, lock never asserted → `lock_err=1` after 100 WAIT_LOCK cycles, `clk_ready=0`, `mode_ready=1`. A new request then clears `lock_err`.
- **Held request:** `mode_valid` held high with spurious `drp_drdy` pulses during RST → exactly one sequence per acceptance, spurious `drdy` ignored, no extra DRP access.
- **Reset mid-write:** assert `rstn_in` low during WR_WAIT of entry 4 → `drp_den`, `drp_dwe` and `mmcm_rst` are 0 within the same cycle. After release the FSM is in WAIT_LOCK with `mode_ready=0`.
- **Lock loss in IDLE:** drop `mmcm_locked` while idle → `clk_ready` falls 3 cycles later, no DRP activity.
